// File: rtl/udp_gmii_tx.sv
// GMII transmit path for one UDP/IPv4 Ethernet II frame per start pulse.
// Builds the headers, fetches the payload a word at a time, pads to 18 bytes and appends the FCS.
module udp_gmii_tx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] SRC_PORT  = 16'd1234,
    parameter logic [15:0] DES_PORT  = 16'd1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start_en,
    input  logic [15:0] tx_byte_num,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    localparam logic [15:0] MAX_PAYLOAD = 16'd1472;
    localparam logic [15:0] MIN_PAYLOAD = 16'd18;

    typedef enum logic [3:0] {
        IDLE, CSUM, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, DATA, FCS, IFG
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [47:0] des_mac_r;
    logic [31:0] des_ip_r;
    logic [15:0] n_r;
    logic [15:0] ident;
    logic [19:0] csum_acc;
    logic [15:0] ip_csum;
    logic [31:0] data_word;
    logic [31:0] crc;

    logic [15:0]      data_len;
    logic [15:0]      ip_len;
    logic [15:0]      udp_len;
    logic [13:0][7:0] eth_hdr;
    logic [19:0][7:0] ip_hdr;
    logic [7:0][7:0]  udp_hdr;
    logic [3:0][7:0]  word_b;
    logic [3:0][7:0]  crc_b;
    logic [19:0]      csum_sum;
    logic [16:0]      fold1;
    logic [15:0]      fold2;
    logic [7:0]       tx_byte;
    logic [31:0]      crc_next;

    // Reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    assign data_len = (n_r < MIN_PAYLOAD) ? MIN_PAYLOAD : n_r;
    assign ip_len   = 16'd28 + n_r;
    assign udp_len  = 16'd8 + n_r;
    assign eth_hdr  = {des_mac_r, BOARD_MAC, 16'h0800};
    assign ip_hdr   = {16'h4500, ip_len, ident, 16'h4000, 16'h4011, ip_csum, BOARD_IP, des_ip_r};
    assign udp_hdr  = {SRC_PORT, DES_PORT, udp_len, 16'h0000};
    assign word_b   = data_word;
    assign crc_b    = crc;

    // Sum is 20 bits wide so nine 16-bit words never overflow before folding.
    assign csum_sum = {4'd0, 16'h4500} + {4'd0, ip_len} + {4'd0, ident}
                    + {4'd0, 16'h4000} + {4'd0, 16'h4011}
                    + {4'd0, BOARD_IP[31:16]} + {4'd0, BOARD_IP[15:0]}
                    + {4'd0, des_ip_r[31:16]} + {4'd0, des_ip_r[15:0]};
    assign fold1    = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
    assign fold2    = fold1[15:0] + {15'd0, fold1[16]};

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            PREAMBLE: tx_byte = (cnt == 16'd7) ? 8'hD5 : 8'h55;
            ETH_HDR:  tx_byte = eth_hdr[4'd13 - cnt[3:0]];
            IP_HDR:   tx_byte = ip_hdr[5'd19 - cnt[4:0]];
            UDP_HDR:  tx_byte = udp_hdr[3'd7 - cnt[2:0]];
            DATA: begin
                // The first byte of each word comes straight off tx_data, the rest from the capture.
                if (cnt < n_r)
                    tx_byte = (cnt[1:0] == 2'd0) ? tx_data[31:24] : word_b[2'd3 - cnt[1:0]];
            end
            FCS:      tx_byte = ~crc_b[cnt[1:0]];
            default:  tx_byte = 8'h00;
        endcase
    end

    assign crc_next = crc8(crc, tx_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            des_mac_r  <= '0;
            des_ip_r   <= '0;
            n_r        <= '0;
            ident      <= '0;
            csum_acc   <= '0;
            ip_csum    <= '0;
            data_word  <= '0;
            crc        <= '1;
            tx_req     <= 1'b0;
            tx_done    <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
        end else begin
            tx_req     <= 1'b0;
            tx_done    <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            case (state)
                IDLE: begin
                    if (tx_start_en) begin
                        des_mac_r <= des_mac;
                        des_ip_r  <= des_ip;
                        n_r       <= (tx_byte_num > MAX_PAYLOAD) ? MAX_PAYLOAD : tx_byte_num;
                        cnt       <= '0;
                        state     <= CSUM;
                    end
                end
                CSUM: begin
                    if (cnt == 16'd0) begin
                        csum_acc <= csum_sum;
                        cnt      <= cnt + 16'd1;
                    end else begin
                        ip_csum <= ~fold2;
                        crc     <= '1;
                        cnt     <= '0;
                        state   <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    if (cnt == 16'd7) begin
                        cnt   <= '0;
                        state <= ETH_HDR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ETH_HDR: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    crc        <= crc_next;
                    if (cnt == 16'd13) begin
                        cnt   <= '0;
                        state <= IP_HDR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IP_HDR: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    crc        <= crc_next;
                    if (cnt == 16'd19) begin
                        ident <= ident + 16'd1;
                        cnt   <= '0;
                        state <= UDP_HDR;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                UDP_HDR: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    crc        <= crc_next;
                    // Word 0 request leads the first payload byte by two cycles.
                    if (cnt == 16'd6 && n_r != 16'd0)
                        tx_req <= 1'b1;
                    if (cnt == 16'd7) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    crc        <= crc_next;
                    if (cnt[1:0] == 2'd0)
                        data_word <= tx_data;
                    if (cnt[1:0] == 2'd2 && (cnt + 16'd2) < n_r)
                        tx_req <= 1'b1;
                    if (cnt == data_len - 16'd1) begin
                        cnt   <= '0;
                        state <= FCS;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FCS: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= tx_byte;
                    if (cnt == 16'd3) begin
                        cnt   <= '0;
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IFG: begin
                    // Twelve idle cycles elapse on the line before tx_done rises.
                    if (cnt == 16'd12) begin
                        tx_done <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
